mem_host_port: RTL

//  Host-side access port to memory_unit: bulk-loads noun words from a host stream into RAM, and dumps RAM back to a host stream.

---
 rtl/mem_host_port_pkg.sv | 18 +
 rtl/mem_host_port.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_host_port_pkg.sv
// mem_host_port_pkg: shared memory-function codes, default widths and FSM encodings
// for the host-side memory access port.
package mem_host_port_pkg;
    localparam logic [1:0] MEM_FUNC_READ  = 2'b00;
    localparam logic [1:0] MEM_FUNC_WRITE = 2'b01;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    typedef enum logic {OP_LOAD = 1'b0, OP_DUMP = 1'b1} op_e;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ARB      = 4'd1;
    localparam logic [3:0] S_LD_IN    = 4'd2;
    localparam logic [3:0] S_LD_ISSUE = 4'd3;
    localparam logic [3:0] S_LD_WAIT  = 4'd4;
    localparam logic [3:0] S_DP_ISSUE = 4'd5;
    localparam logic [3:0] S_DP_WAIT  = 4'd6;
    localparam logic [3:0] S_DP_PUSH  = 4'd7;
    localparam logic [3:0] S_FIN      = 4'd8;
endpackage

// File: rtl/mem_host_port.sv
// mem_host_port: host stream port that bulk-loads words into RAM and dumps RAM back out,
// acting as a bus initiator through a req/gnt pair to the memory mux.
module mem_host_port
    import mem_host_port_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [CNT_W-1:0]  cmd_count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              done_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    input  logic              mem_ready_i,
    output logic              mem_execute_o,
    output logic [1:0]        mem_func_o,
    output logic [ADDR_W-1:0] address1_o,
    output logic [ADDR_W-1:0] address2_o,
    output logic [DATA_W-1:0] write_data_o,
    input  logic [DATA_W-1:0] read_data1_i
);
    logic [3:0]        state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              issuing, issue, waiting, complete, advance;

    assign issuing  = state_q == S_LD_ISSUE || state_q == S_DP_ISSUE;
    assign issue    = issuing && mem_ready_i && bus_gnt_i;
    assign waiting  = state_q == S_LD_WAIT || state_q == S_DP_WAIT;
    // memory_unit drops ready after the strobe; the op is done once ready returns
    assign complete = waiting && busy_q && mem_ready_i;
    assign advance  = (state_q == S_LD_WAIT && complete) || (state_q == S_DP_PUSH && out_ready_i);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = advance ? addr_q + 1'b1 : addr_q;
        rem_d   = advance ? rem_q - 1'b1 : rem_q;
        wdata_d = (state_q == S_LD_IN && in_valid_i) ? in_data_i : wdata_q;
        rdata_d = (state_q == S_DP_WAIT && complete) ? read_data1_i : rdata_q;
        busy_d  = issue ? 1'b0 : (waiting && !mem_ready_i) ? 1'b1 : busy_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid_i) begin
                op_d    = op_e'(cmd_op_i);
                addr_d  = cmd_base_i;
                rem_d   = cmd_count_i;
                state_d = cmd_count_i == '0 ? S_FIN : S_ARB;
            end
            S_ARB:      if (bus_gnt_i) state_d = op_q == OP_DUMP ? S_DP_ISSUE : S_LD_IN;
            S_LD_IN:    if (in_valid_i) state_d = S_LD_ISSUE;
            S_LD_ISSUE: if (issue) state_d = S_LD_WAIT;
            S_LD_WAIT:  if (complete) state_d = rem_q == CNT_W'(1) ? S_FIN : S_LD_IN;
            S_DP_ISSUE: if (issue) state_d = S_DP_WAIT;
            S_DP_WAIT:  if (complete) state_d = S_DP_PUSH;
            S_DP_PUSH:  if (out_ready_i) state_d = rem_q == CNT_W'(1) ? S_FIN : S_DP_ISSUE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_ready_o   = state_q == S_IDLE;
    assign in_ready_o    = state_q == S_LD_IN;
    assign out_valid_o   = state_q == S_DP_PUSH;
    assign out_data_o    = rdata_q;
    assign done_o        = state_q == S_FIN;
    assign bus_req_o     = !(state_q == S_IDLE || state_q == S_FIN);
    assign mem_execute_o = issue;
    assign mem_func_o    = state_q == S_LD_ISSUE ? MEM_FUNC_WRITE : MEM_FUNC_READ;
    assign address1_o    = issuing ? addr_q : '0;
    assign address2_o    = '0;
    assign write_data_o  = state_q == S_LD_ISSUE ? wdata_q : '0;
endmodule
